// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm_seq step sequencer.
//   t_seq_state   : sequencer state encoding (Idle, Run, Finish)
//   DEF_NUM_STEPS : default number of run steps
//   DEF_CTR_BITS  : default width of each per-step dwell count
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } t_seq_state;

    localparam int DEF_NUM_STEPS = 4;
    localparam int DEF_CTR_BITS  = 8;

endpackage

// File: rtl/seq_dwell_ctr.sv
// Dwell counter for one sequencer step.
//   clk, rst_n : clock, async active-low reset
//   clear      : force count to 0 on the next edge (wins over enable)
//   enable     : increment count on the next edge
//   end_val    : last count value of the current step
//   count      : current count
//   at_end     : count has reached end_val
module seq_dwell_ctr #(
    parameter int CTR_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    input  logic [CTR_BITS-1:0] end_val,
    output logic [CTR_BITS-1:0] count,
    output logic                at_end
);

    logic [CTR_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + CTR_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count  = cnt_q;
    // The owner clears on at_end, so the count never goes past end_val.
    assign at_end = (cnt_q == end_val);

endmodule

// File: rtl/fsm_seq.sv
// Step sequencer: on start, walks steps 0..NUM_STEPS-1, dwelling max(d_k,1)
// cycles in each, then spends one Finish cycle and either returns to Idle or
// loops back to step 0 with the same latched dwell table.
//   in_clk, in_rst_n : clock, async active-low reset
//   in_start         : start request (Idle only)
//   in_abort         : synchronous abort (Run/Finish), highest priority
//   in_loop          : loop mode, latched at start
//   in_delays        : per-step dwell, step k at [k*CTR_BITS +: CTR_BITS]
//   out_busy         : state != Idle
//   out_step         : current step index
//   out_step_enter   : first cycle of a step
//   out_done         : the Finish cycle
//   out_wait_ctr     : dwell counter
module fsm_seq
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int CTR_BITS  = DEF_CTR_BITS
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_start,
    input  logic                          in_abort,
    input  logic                          in_loop,
    input  logic [NUM_STEPS*CTR_BITS-1:0] in_delays,
    output logic                          out_busy,
    output logic [$clog2(NUM_STEPS)-1:0]  out_step,
    output logic                          out_step_enter,
    output logic                          out_done,
    output logic [CTR_BITS-1:0]           out_wait_ctr
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    t_seq_state                          state_q, state_d;
    logic [STEP_W-1:0]                   step_q, step_d;
    logic [NUM_STEPS-1:0][CTR_BITS-1:0]  dly_q, dly_d;
    logic                                loop_q, loop_d;

    logic                ctr_clr, ctr_en, ctr_at_end;
    logic [CTR_BITS-1:0] ctr_val, cur_dly, end_val;

    // A dwell of 0 behaves as 1, so the end value saturates at 0.
    assign cur_dly = dly_q[step_q];
    assign end_val = (cur_dly == '0) ? '0 : cur_dly - CTR_BITS'(1);

    seq_dwell_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .clear   (ctr_clr),
        .enable  (ctr_en),
        .end_val (end_val),
        .count   (ctr_val),
        .at_end  (ctr_at_end)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dly_d   = dly_q;
        loop_d  = loop_q;
        ctr_clr = 1'b1;
        ctr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_start && !in_abort) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                    dly_d   = in_delays;
                    loop_d  = in_loop;
                end
            end
            ST_RUN: begin
                if (in_abort) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (ctr_at_end) begin
                    if (step_q == LAST_STEP)
                        state_d = ST_FINISH;
                    else
                        step_d = step_q + STEP_W'(1);
                end else begin
                    ctr_clr = 1'b0;
                    ctr_en  = 1'b1;
                end
            end
            ST_FINISH: begin
                // Looping reuses the latched dwell table.
                state_d = (loop_q && !in_abort) ? ST_RUN : ST_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            dly_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dly_q   <= dly_d;
            loop_q  <= loop_d;
        end
    end

    assign out_busy       = (state_q != ST_IDLE);
    assign out_step       = step_q;
    assign out_step_enter = (state_q == ST_RUN) && (ctr_val == '0);
    assign out_done       = (state_q == ST_FINISH);
    assign out_wait_ctr   = ctr_val;

endmodule

// File: tb/tb_fsm_seq.sv
module tb_fsm_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, loop_m = 1'b0;
    logic [15:0] delays = '0;
    logic        busy, enter, done;
    logic [1:0]  step;
    logic [3:0]  ctr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fsm_seq #(.NUM_STEPS(4), .CTR_BITS(4)) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_start       (start),
        .in_abort       (abort),
        .in_loop        (loop_m),
        .in_delays      (delays),
        .out_busy       (busy),
        .out_step       (step),
        .out_step_enter (enter),
        .out_done       (done),
        .out_wait_ctr   (ctr)
    );

    // One row: inputs driven before an edge, outputs expected after it.
    typedef struct {
        logic        s, a, l;
        logic [15:0] d;
        logic        b;
        logic [1:0]  st;
        logic        st_chk;
        logic        en, dn;
        logic [3:0]  c;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic s, a, l, input logic [15:0] d,
                       input logic b, input logic [1:0] st, input logic st_chk,
                       input logic en, dn, input logic [3:0] c);
        row_t r;
        r.s = s; r.a = a; r.l = l; r.d = d;
        r.b = b; r.st = st; r.st_chk = st_chk; r.en = en; r.dn = dn; r.c = c;
        tbl.push_back(r);
    endtask

    task automatic run_tbl(input string name, input int n);
        for (int i = 0; i < tbl.size() && i < n; i++) begin
            @(negedge clk);
            start = tbl[i].s; abort = tbl[i].a; loop_m = tbl[i].l; delays = tbl[i].d;
            @(posedge clk);
            #1;
            total++;
            if (busy !== tbl[i].b || enter !== tbl[i].en || done !== tbl[i].dn ||
                ctr !== tbl[i].c || (tbl[i].st_chk && step !== tbl[i].st)) begin
                bad++;
                $display("FAIL %s row %0d: got busy=%b step=%0d enter=%b done=%b ctr=%0d exp busy=%b step=%0d enter=%b done=%b ctr=%0d",
                         name, i, busy, step, enter, done, ctr,
                         tbl[i].b, tbl[i].st, tbl[i].en, tbl[i].dn, tbl[i].c);
            end
        end
        tbl.delete();
        @(negedge clk);
        start = 1'b0; abort = 1'b0; loop_m = 1'b0;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (busy !== 1'b0 || enter !== 1'b0 || done !== 1'b0 || step !== 2'd0 || ctr !== 4'd0) begin
            bad++;
            $display("FAIL %s: got busy=%b step=%0d enter=%b done=%b ctr=%0d exp all 0",
                     name, busy, step, enter, done, ctr);
        end
    endtask

    // Delays {5,1,1,1}, no loop: 5 cycles in step 0, then 1 each, Finish, Idle.
    task automatic load_a();
        add(1,0,0,16'h1115, 1,0,1, 1,0,0);
        add(0,0,0,16'h1115, 1,0,1, 0,0,1);
        add(0,0,0,16'h1115, 1,0,1, 0,0,2);
        add(0,0,0,16'h1115, 1,0,1, 0,0,3);
        add(0,0,0,16'h1115, 1,0,1, 0,0,4);
        add(0,0,0,16'h1115, 1,1,1, 1,0,0);
        add(0,0,0,16'h1115, 1,2,1, 1,0,0);
        add(0,0,0,16'h1115, 1,3,1, 1,0,0);
        add(0,0,0,16'h1115, 1,3,1, 0,1,0);
        add(0,0,0,16'h1115, 0,0,0, 0,0,0);
    endtask

    initial begin
        // Reset state.
        #3;
        check_zero("reset_state");
        @(posedge clk); #1;
        check_zero("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sequence.
        load_a();
        run_tbl("seq_5111", 100);

        // All-zero dwells behave as 1.
        add(1,0,0,16'h0000, 1,0,1, 1,0,0);
        add(0,0,0,16'h0000, 1,1,1, 1,0,0);
        add(0,0,0,16'h0000, 1,2,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 0,1,0);
        add(0,0,0,16'h0000, 0,0,0, 0,0,0);
        run_tbl("seq_0000", 100);

        // Loop mode; inputs changed during Finish must not re-latch; abort in step 2.
        add(1,0,1,16'h1112, 1,0,1, 1,0,0);
        add(0,0,1,16'h1112, 1,0,1, 0,0,1);
        add(0,0,1,16'h1112, 1,1,1, 1,0,0);
        add(0,0,1,16'h1112, 1,2,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 0,1,0);
        add(0,0,0,16'h0000, 1,0,1, 1,0,0);
        add(0,0,0,16'h0000, 1,0,1, 0,0,1);
        add(0,0,0,16'h0000, 1,1,1, 1,0,0);
        add(0,0,0,16'h0000, 1,2,1, 1,0,0);
        add(0,1,0,16'h0000, 0,0,1, 0,0,0);
        add(0,0,0,16'h0000, 0,0,1, 0,0,0);
        add(0,0,0,16'h0000, 0,0,1, 0,0,0);
        run_tbl("seq_loop_abort", 100);

        // Start with abort in Idle stays Idle; abort alone in Idle is ignored.
        add(1,1,0,16'h1115, 0,0,1, 0,0,0);
        add(0,1,0,16'h1115, 0,0,1, 0,0,0);
        // Start during Run with new dwells is ignored.
        add(1,0,0,16'h1115, 1,0,1, 1,0,0);
        add(1,0,1,16'h0000, 1,0,1, 0,0,1);
        add(1,0,1,16'h0000, 1,0,1, 0,0,2);
        add(1,0,1,16'h0000, 1,0,1, 0,0,3);
        add(0,0,0,16'h0000, 1,0,1, 0,0,4);
        add(0,0,0,16'h0000, 1,1,1, 1,0,0);
        add(0,0,0,16'h0000, 1,2,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 1,0,0);
        add(0,0,0,16'h0000, 1,3,1, 0,1,0);
        add(0,0,0,16'h0000, 0,0,0, 0,0,0);
        run_tbl("seq_ignore_start", 100);

        // Reset mid-step 1, between edges: outputs drop at once.
        load_a();
        run_tbl("seq_pre_reset", 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_step1");
        @(posedge clk); #1;
        check_zero("reset_mid_held");
        @(negedge clk);
        rst_n = 1'b1;
        load_a();
        run_tbl("seq_after_reset", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not end, got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/fsm_seq.md
FSM_SEQ -- requirements
Module: fsm_seq

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 4: number of run steps, legal range 2..16.
REQ-002 SHALL have parameter CTR_BITS, default 8: width of each per-step dwell count.
REQ-003 SHALL have port in_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port in_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_start, input, 1 bit: start request, sampled only in Idle.
REQ-006 SHALL have port in_abort, input, 1 bit: abort request, synchronous.
REQ-007 SHALL have port in_loop, input, 1 bit: loop mode, latched at start.
REQ-008 SHALL have port in_delays, input, NUM_STEPS*CTR_BITS bits: dwell of step k in bits [k*CTR_BITS +: CTR_BITS], latched at start.
REQ-009 SHALL have port out_busy, output, 1 bit: high whenever state is not Idle.
REQ-010 SHALL have port out_step, output, $clog2(NUM_STEPS) bits: current step index.
REQ-011 SHALL have port out_step_enter, output, 1 bit: high in the first cycle of each step.
REQ-012 SHALL have port out_done, output, 1 bit: high for exactly the one Finish cycle.
REQ-013 SHALL have port out_wait_ctr, output, CTR_BITS bits: dwell counter value.

Function
REQ-014 SHALL implement the states Idle, Run and Finish.
REQ-015 In Idle, in_start=1 and in_abort=0 at an edge SHALL give, after that edge: Run, step 0, counter 0, with in_delays and in_loop latched.
REQ-016 In Run, step k SHALL last max(d_k,1) cycles, where d_k is the latched dwell; a dwell of 0 is treated as 1.
REQ-017 In Run, when counter = max(d_k,1)-1, the next edge SHALL clear the counter and advance step k to k+1; otherwise the counter increments by 1.
REQ-018 When the counter reaches its end value on the last step (NUM_STEPS-1), the next edge SHALL enter Finish with step held at NUM_STEPS-1.
REQ-019 From Finish, the next edge SHALL go to Run, step 0, counter 0 if the latched loop bit is 1, else to Idle; in loop mode in_delays SHALL NOT be re-latched.
REQ-020 in_abort=1 at an edge in Run or Finish SHALL force Idle, step 0, counter 0, with no out_done pulse; abort SHALL have priority over all other transitions.
REQ-021 in_abort is ignored in Idle; in_start and in_abort both high in Idle SHALL leave the block in Idle.
REQ-022 in_start while busy SHALL be ignored; no restart, no re-latch.
REQ-023 out_step_enter SHALL be defined as (state = Run and counter = 0).
REQ-024 out_done SHALL be defined as (state = Finish).
REQ-025 Counter arithmetic SHALL be CTR_BITS wide and never wrap, because the compare happens before any overflow.

Reset
REQ-026 While in_rst_n=0, regardless of clock, the block SHALL hold: state Idle, step 0, counter 0, latched delays 0, latched loop 0.
REQ-027 During reset the outputs SHALL be: out_busy 0, out_done 0, out_step_enter 0, out_step 0, out_wait_ctr 0.
REQ-028 Reset asserted mid-Run SHALL abandon the sequence immediately, with no done pulse.
REQ-029 After release of in_rst_n, the first start SHALL be accepted at the first rising edge.

Structure
REQ-030 Package fsm_seq_pkg SHALL hold the state enum t_seq_state (Idle, Run, Finish) and the default NUM_STEPS and CTR_BITS constants.
REQ-031 The dwell counter SHALL be a sub-module, seq_dwell_ctr (inputs: clear, enable, end value; outputs: count, at-end).
REQ-032 State register and next-state logic SHALL be separate sequential and combinational processes.

Verification (NUM_STEPS=4, CTR_BITS=4)
REQ-033 Delays {5,1,1,1}, loop=0, start at edge E0 -> step 0 for 5 cycles, then steps 1, 2, 3 one cycle each; Finish after E8; done high one cycle; Idle after E9; 4 out_step_enter pulses.
REQ-034 Delays {0,0,0,0} -> 1 cycle per step; Finish after E4; Idle after E5.
REQ-035 Loop=1, delays {2,1,1,1} -> Run at step 0 again directly after each Finish, done pulse every 6 cycles; abort during step 2 -> Idle next edge, no further done.
REQ-036 Start together with abort in Idle -> stays Idle; start while in Run with different in_delays -> ignored, the original timing is kept.
REQ-037 in_rst_n driven low mid-step 1 between edges -> outputs 0 immediately; after release, a new start yields the full 8-cycle sequence of REQ-033.
